// File: rtl/mdu_pkg.sv
// Shared MDU types and defaults.
//   word_t / rob_id_t : result word and reorder-buffer id carried through writeback
//   MUL_LAT_DEF / DIV_LAT_DEF / WB_DEPTH_DEF : default latencies and FIFO depth
//   sched_entry_t : one completion-schedule slot (valid, rob_id)
package mdu_pkg;

   localparam int WORD_W   = 32;
   localparam int ROB_ID_W = 6;

   typedef logic [WORD_W-1:0]   word_t;
   typedef logic [ROB_ID_W-1:0] rob_id_t;

   localparam int MUL_LAT_DEF  = 2;
   localparam int DIV_LAT_DEF  = 34;
   localparam int WB_DEPTH_DEF = 4;

   typedef struct packed {
      logic    valid;
      rob_id_t rob_id;
   } sched_entry_t;

endpackage

// File: rtl/mdu_wb_fifo.sv
// Writeback FIFO for MDU results. Outputs come straight from storage registers,
// so a push in cycle c is visible at the head in cycle c+1.
// Ports:
//   clk, rst_n (sync, active low), flush    : clock, reset, discard contents
//   push, push_data, push_rob_id            : enqueue one result
//   pop_ready                               : downstream ready; pop = wb_valid & pop_ready
//   wb_valid, wb_data, wb_rob_id            : FIFO head
//   count                                   : registered occupancy
module mdu_wb_fifo
   import mdu_pkg::*;
#(
   parameter int DEPTH = WB_DEPTH_DEF,
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  word_t         push_data,
   input  rob_id_t       push_rob_id,
   input  logic          pop_ready,
   output logic          wb_valid,
   output word_t         wb_data,
   output rob_id_t       wb_rob_id,
   output logic [CW-1:0] count
);

   word_t         data_q [DEPTH];
   rob_id_t       rob_q  [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] cnt_q;
   logic          pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      logic [PW-1:0] r;
      if (p == PW'(DEPTH - 1)) r = '0;
      else                     r = p + 1'b1;
      return r;
   endfunction

   assign pop = (cnt_q != '0) && pop_ready;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            rob_q[i]  <= '0;
         end
      end else begin
         if (push) begin
            data_q[wr_ptr_q] <= push_data;
            rob_q[wr_ptr_q]  <= push_rob_id;
            wr_ptr_q         <= ptr_inc(wr_ptr_q);
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   assign wb_valid  = (cnt_q != '0);
   assign wb_data   = data_q[rd_ptr_q];
   assign wb_rob_id = rob_q[rd_ptr_q];
   assign count     = cnt_q;

endmodule

// File: rtl/mdu_sched.sv
// MDU issue scheduler: round-robin arbitration between two requesters, a
// completion schedule that predicts which cycle each result appears on
// res_data_i, and a credit check so results always fit in the writeback FIFO.
// Ports:
//   clk, rst_n (sync, active low), flush
//   req_valid_i/req_is_div_i/req_rob_id_i   : per-requester issue requests
//   req_ready_o                             : per-requester grant (one-hot or zero)
//   issue_valid_o/issue_sel_o/issue_is_div_o: operand latch strobe, mux select, op class
//   res_data_i                              : MDU result bus, captured on scheduled completion
//   wb_valid_o/wb_data_o/wb_rob_id_o        : writeback FIFO head
//   wb_ready_i                              : downstream ready
module mdu_sched
   import mdu_pkg::*;
#(
   parameter int MUL_LAT  = MUL_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int WB_DEPTH = WB_DEPTH_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic [1:0]    req_valid_i,
   input  logic [1:0]    req_is_div_i,
   input  rob_id_t [1:0] req_rob_id_i,
   output logic [1:0]    req_ready_o,
   output logic          issue_valid_o,
   output logic          issue_sel_o,
   output logic          issue_is_div_o,
   input  word_t         res_data_i,
   output logic          wb_valid_o,
   output word_t         wb_data_o,
   output rob_id_t       wb_rob_id_o,
   input  logic          wb_ready_i
);

   localparam int CW  = $clog2(WB_DEPTH + 1);
   localparam int DCW = (DIV_LAT > 2) ? $clog2(DIV_LAT) : 1;

   // sched_q[k] is the op whose result is on res_data_i k cycles from now.
   // A grant with latency L lands in slot L-1 of the next cycle, so the
   // highest slot ever occupied is DIV_LAT-1.
   sched_entry_t   sched_q [DIV_LAT];
   logic [CW-1:0]  in_flight_q;
   logic [CW-1:0]  wb_count;
   logic [DCW-1:0] div_cnt_q;
   logic           ptr_q;

   logic           credit_ok;
   logic           mul_slot_free;
   logic           div_idle;
   logic           complete;
   logic [1:0]     elig;
   logic           gnt;
   logic           gnt_idx;
   logic           gnt_is_div;
   rob_id_t        gnt_rob;

   assign credit_ok     = ({1'b0, in_flight_q} + {1'b0, wb_count}) < (CW+1)'(WB_DEPTH);
   assign mul_slot_free = !sched_q[MUL_LAT].valid;
   // A divide can never collide on its completion slot: nothing in flight
   // completes later than DIV_LAT-1 cycles from now.
   assign div_idle      = (div_cnt_q == '0);
   assign complete      = sched_q[0].valid;

   always_comb begin
      elig        = '0;
      gnt         = 1'b0;
      gnt_idx     = 1'b0;
      req_ready_o = '0;
      for (int i = 0; i < 2; i++) begin
         elig[i] = req_valid_i[i] && credit_ok &&
                   (req_is_div_i[i] ? div_idle : mul_slot_free);
      end
      if (rst_n && !flush) begin
         if (elig[ptr_q]) begin
            gnt     = 1'b1;
            gnt_idx = ptr_q;
         end else if (elig[~ptr_q]) begin
            gnt     = 1'b1;
            gnt_idx = ~ptr_q;
         end
      end
      if (gnt) req_ready_o[gnt_idx] = 1'b1;
   end

   assign gnt_is_div     = req_is_div_i[gnt_idx];
   assign gnt_rob        = req_rob_id_i[gnt_idx];
   assign issue_valid_o  = gnt;
   assign issue_sel_o    = gnt_idx;
   assign issue_is_div_o = gnt && gnt_is_div;

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         for (int k = 0; k < DIV_LAT; k++) sched_q[k] <= '0;
         in_flight_q <= '0;
         div_cnt_q   <= '0;
         ptr_q       <= 1'b0;
      end else begin
         for (int k = 0; k < DIV_LAT - 1; k++) sched_q[k] <= sched_q[k+1];
         sched_q[DIV_LAT-1] <= '0;
         if (gnt) begin
            if (gnt_is_div) sched_q[DIV_LAT-1] <= sched_entry_t'{valid: 1'b1, rob_id: gnt_rob};
            else            sched_q[MUL_LAT-1] <= sched_entry_t'{valid: 1'b1, rob_id: gnt_rob};
            ptr_q <= ~gnt_idx;
         end
         case ({gnt, complete})
            2'b10:   in_flight_q <= in_flight_q + 1'b1;
            2'b01:   in_flight_q <= in_flight_q - 1'b1;
            default: in_flight_q <= in_flight_q;
         endcase
         // Divider blocks further divides for DIV_LAT-2 cycles after the grant,
         // so the next divide may go DIV_LAT-1 cycles after the previous one.
         if (gnt && gnt_is_div) div_cnt_q <= DCW'(DIV_LAT - 2);
         else if (!div_idle)    div_cnt_q <= div_cnt_q - 1'b1;
      end
   end

   mdu_wb_fifo #(
      .DEPTH (WB_DEPTH)
   ) u_wb_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (flush),
      .push        (complete),
      .push_data   (res_data_i),
      .push_rob_id (sched_q[0].rob_id),
      .pop_ready   (wb_ready_i),
      .wb_valid    (wb_valid_o),
      .wb_data     (wb_data_o),
      .wb_rob_id   (wb_rob_id_o),
      .count       (wb_count)
   );

endmodule
